// File: rtl/int_arb.sv
// Fixed-priority interrupt arbiter: masks peripheral requests, presents one vector at a
// time to the CPU and returns a one-cycle acknowledge pulse to the serviced source.
module int_arb #(
   parameter int         NSRC      = 8,
   parameter int         VEC_BASE  = 1,
   parameter logic [7:0] IMSK_ADDR = 8'h7E,
   parameter logic [7:0] IPND_ADDR = 8'h7F
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src_irq,
   output logic [NSRC-1:0] src_ack,
   input  logic            global_ie,
   output logic            cpu_irq,
   output logic [4:0]      cpu_vec,
   input  logic            cpu_ack,
   input  logic [7:0]      addr,
   input  logic [7:0]      wdata,
   input  logic            write,
   input  logic            read,
   output logic [7:0]      rdata
);

   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK,
      GAP
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cur_q, cur_d;
   logic [IW-1:0]   win;
   logic [NSRC-1:0] imsk_q, imsk_d;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] src_ack_q, src_ack_d;
   logic            cpu_irq_q, cpu_irq_d;
   logic [4:0]      cpu_vec_q, cpu_vec_d;
   logic [15:0]     imsk_ext;
   logic [15:0]     ipnd_ext;

   assign pending = src_irq & imsk_q;

   // Scan from the top down so the lowest set index is the one left standing.
   always_comb begin
      win = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i]) win = IW'(i);
      end
   end

   always_comb begin
      imsk_d = imsk_q;
      if (write && (addr == IMSK_ADDR)) imsk_d = NSRC'(wdata);
   end

   assign imsk_ext = 16'(imsk_q);
   assign ipnd_ext = 16'(pending);

   always_comb begin
      rdata = 8'h00;
      if (read) begin
         if (addr == IMSK_ADDR)      rdata = imsk_ext[7:0];
         else if (addr == IPND_ADDR) rdata = ipnd_ext[7:0];
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned
   // (which would infer a latch).
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      cpu_irq_d = cpu_irq_q;
      cpu_vec_d = cpu_vec_q;
      src_ack_d = '0;
      unique case (state_q)
         IDLE: begin
            cpu_irq_d = 1'b0;
            cpu_vec_d = 5'd0;
            if (global_ie && (pending != '0)) begin
               state_d   = REQ;
               cur_d     = win;
               cpu_irq_d = 1'b1;
               cpu_vec_d = 5'(VEC_BASE) + 5'(win);
            end
         end
         REQ: begin
            // Acknowledge takes precedence over a simultaneous withdraw.
            if (cpu_ack) begin
               state_d   = ACK;
               cpu_irq_d = 1'b0;
               cpu_vec_d = 5'd0;
               src_ack_d = NSRC'(1) << cur_q;
            end else if (!global_ie || !pending[cur_q]) begin
               state_d   = IDLE;
               cpu_irq_d = 1'b0;
               cpu_vec_d = 5'd0;
            end
         end
         ACK: begin
            state_d   = GAP;
            cpu_irq_d = 1'b0;
            cpu_vec_d = 5'd0;
         end
         GAP: begin
            // Dead cycle: lets the acknowledged source's registered request fall.
            state_d   = IDLE;
            cpu_irq_d = 1'b0;
            cpu_vec_d = 5'd0;
         end
         default: begin
            state_d   = IDLE;
            cpu_irq_d = 1'b0;
            cpu_vec_d = 5'd0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together
   // from values sampled before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         imsk_q    <= '0;
         cpu_irq_q <= 1'b0;
         cpu_vec_q <= 5'd0;
         src_ack_q <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         imsk_q    <= imsk_d;
         cpu_irq_q <= cpu_irq_d;
         cpu_vec_q <= cpu_vec_d;
         src_ack_q <= src_ack_d;
      end
   end

   assign cpu_irq = cpu_irq_q;
   assign cpu_vec = cpu_vec_q;
   assign src_ack = src_ack_q;

endmodule

// File: doc/int_arb.md
INT_ARB -- requirements
Module: int_arb

Interface
REQ-001 Parameter NSRC, default 8, number of peripheral interrupt sources (2..16).
REQ-002 Parameter VEC_BASE, default 1, vector number of source 0.
REQ-003 Parameter IMSK_ADDR, default 8'h7E, bus address of mask register IMSK (bits [7:0] = sources 7..0).
REQ-004 Parameter IPND_ADDR, default 8'h7F, bus address of read-only pending register IPND.
REQ-005 Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_irq  in  NSRC  level interrupt requests from peripherals (e.g. timer interrupt_request).
- src_ack  out  NSRC  one-hot, one-cycle "interrupt executed" pulse back to the serviced source.
- global_ie  in  1  CPU status-register I flag.
- cpu_irq  out  1  interrupt request to CPU core.
- cpu_vec  out  5  vector number presented with cpu_irq.
- cpu_ack  in  1  CPU has taken the vector (one-cycle pulse).
- addr  in  8  register bus address.
- wdata  in  8  write data.
- write  in  1  write strobe, single cycle.
- read  in  1  read strobe.
- rdata  out  8  read data, combinational.

Function
REQ-006 pending = src_irq & IMSK[NSRC-1:0]; IPND reads pending zero-extended to 8 bits.
REQ-007 Winner = lowest-index set bit of pending (fixed priority, source 0 highest).
REQ-008 FSM states IDLE, REQ, ACK, GAP; reset state IDLE.
REQ-009 IDLE: if global_ie=1 and pending!=0, latch winner into cur, go REQ; cpu_irq=1 and cpu_vec=VEC_BASE+cur from the next cycle (registered outputs).
REQ-010 REQ: cpu_irq and cpu_vec held stable; a higher-priority source arriving does not change cur or cpu_vec.
REQ-011 REQ, cpu_ack=1: go ACK; cpu_irq=0 next cycle; src_ack[cur]=1 for exactly the next cycle.
REQ-012 REQ, cpu_ack=0 and (global_ie=0 or pending[cur]=0): withdraw -- go IDLE, cpu_irq=0 next cycle, no src_ack.
REQ-013 cpu_ack and withdraw condition in same cycle: cpu_ack wins (ACK path).
REQ-014 ACK: src_ack[cur] asserted; go GAP unconditionally.
REQ-015 GAP: one dead cycle so the acknowledged source's registered request can drop; go IDLE; no arbitration in GAP.
REQ-016 cpu_ack outside REQ is ignored.
REQ-017 Minimum spacing between two cpu_irq rising edges: 4 cycles (REQ->ACK->GAP->IDLE->REQ).
REQ-018 cpu_vec = 0 whenever cpu_irq=0.
REQ-019 Write to IMSK_ADDR: IMSK <= wdata next edge; bits >= NSRC read 0; IPND writes ignored.
REQ-020 IMSK write during REQ clearing bit cur withdraws per REQ-012 on the following cycle.
REQ-021 rdata: IMSK at IMSK_ADDR, IPND at IPND_ADDR when read=1; otherwise 8'h00.
REQ-022 Vector width: VEC_BASE+NSRC-1 <= 31; cpu_vec computed in 5 bits, no wrap.

Reset
REQ-023 rst=1 asynchronously forces: state IDLE, cur=0, IMSK=0, cpu_irq=0, cpu_vec=0, src_ack=0.
REQ-024 Reset asserted in REQ or ACK drops cpu_irq/src_ack immediately; no src_ack pulse after reset release.
REQ-025 After reset release, first arbitration occurs on the first edge with rst=0.

Verification
REQ-026 IMSK=8'h01, global_ie=1, src_irq[0] rises -> cpu_irq=1, cpu_vec=1 one cycle later; cpu_ack pulse -> src_ack=8'h01 for one cycle, cpu_irq=0.
REQ-027 IMSK=8'hFF, src_irq=8'h28 simultaneously -> cpu_vec=4 (source 3); after ack and GAP with src_irq=8'h20 -> cpu_vec=6.
REQ-028 In REQ for source 5, src_irq[1] rises -> cpu_vec stays 6 until cpu_ack; next request cpu_vec=2.
REQ-029 In REQ, global_ie drops without cpu_ack -> cpu_irq=0 next cycle, src_ack stays 0; global_ie returns -> request re-issued.
REQ-030 Write IMSK=8'hA5, read IMSK_ADDR -> 8'hA5; src_irq=8'hFF, read IPND_ADDR -> 8'hA5; read other address -> 8'h00.
REQ-031 rst pulsed while cpu_irq=1 -> cpu_irq=0, cpu_vec=0, IMSK=0 immediately; no request after release until IMSK rewritten.
